// File: rtl/aes_pkg.sv
// Shared AES types and helpers.
// Used by the MixColumns datapath and its sequencer.
package aes_pkg;

  typedef logic [127:0] state_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } fsm_e;

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
  endfunction

  function automatic logic [7:0] x3(input logic [7:0] x);
    return xtime(x) ^ x;
  endfunction

endpackage

// File: rtl/mix_column_unit.sv
// One-column GF(2^8) MixColumns mixer.
// Bypass passes the column through untouched.
module mix_column_unit
  import aes_pkg::*;
(
  input  logic [31:0] col_in,
  input  logic        bypass,
  output logic [31:0] col_out
);

  logic [7:0] a0, a1, a2, a3;
  logic [7:0] b0, b1, b2, b3;

  assign a0 = col_in[31:24];
  assign a1 = col_in[23:16];
  assign a2 = col_in[15:8];
  assign a3 = col_in[7:0];

  // Column mix, a0 is the top byte of the column.
  always_comb begin
    b0 = xtime(a0) ^ x3(a1) ^ a2 ^ a3;
    b1 = a0 ^ xtime(a1) ^ x3(a2) ^ a3;
    b2 = a0 ^ a1 ^ xtime(a2) ^ x3(a3);
    b3 = x3(a0) ^ a1 ^ a2 ^ xtime(a3);
  end

  assign col_out = bypass ? col_in : {b0, b1, b2, b3};

endmodule

// File: rtl/mix_columns_seq.sv
// Sequential MixColumns: one or more columns per clock.
// Handshaked in and out; abort drops the block in flight.
module mix_columns_seq
  import aes_pkg::*;
#(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] state_in,
  input  logic         last_round,
  input  logic         abort,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] state_out
);

  localparam int CPC = COLS_PER_CYCLE;
  localparam logic [2:0] STEP = 3'(CPC);

  fsm_e   state_q, state_d;
  state_t data_q, out_q;
  logic   last_q;
  logic [1:0] cnt_q;
  logic [2:0] cnt_nxt;
  logic   last_col;
  logic   accept;

  logic [1:0]  col_idx [CPC];
  logic [31:0] col_src [CPC];
  logic [31:0] col_res [CPC];

  assign cnt_nxt  = {1'b0, cnt_q} + STEP;
  assign last_col = cnt_nxt[2];
  assign accept   = in_valid & in_ready & ~abort;

  // Column lanes: lane k handles column cnt+k.
  for (genvar k = 0; k < CPC; k++) begin : g_lane
    assign col_idx[k] = cnt_q + 2'(k);
    assign col_src[k] = data_q[{~col_idx[k], 5'b0} +: 32];
    mix_column_unit u_mix (
      .col_in (col_src[k]),
      .bypass (last_q),
      .col_out(col_res[k])
    );
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state and handshake outputs; abort wins over everything.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = BUSY;
      end
      BUSY: if (last_col) state_d = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (abort) state_d = IDLE;
  end

  // Capture on accept, then write result columns while busy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
      out_q  <= '0;
      last_q <= 1'b0;
      cnt_q  <= 2'd0;
    end else if (abort) begin
      cnt_q <= 2'd0;
    end else if (accept) begin
      data_q <= state_in;
      last_q <= last_round;
      cnt_q  <= 2'd0;
    end else if (state_q == BUSY) begin
      for (int k = 0; k < CPC; k++) begin
        out_q[{~col_idx[k], 5'b0} +: 32] <= col_res[k];
      end
      cnt_q <= cnt_nxt[1:0];
    end
  end

  assign state_out = out_q;

endmodule

// File: tb/tb_mix_columns_seq.sv
// Directed bench for mix_columns_seq.
// Runs widths 1, 2 and 4 side by side on shared stimulus.
module tb_mix_columns_seq;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         in_valid = 1'b0;
  logic [127:0] state_in = '0;
  logic         last_round = 1'b0;
  logic         abort = 1'b0;
  logic         out_ready = 1'b1;

  logic         in_ready_w  [3];
  logic         out_valid_w [3];
  logic [127:0] state_out_w [3];

  int vectors = 0;
  int miscompares = 0;
  int lat [3];
  logic [127:0] res [3];
  int exp_lat [3] = '{4, 2, 1};

  localparam logic [127:0] V1_IN  = 128'hdb135345_01010101_01010101_01010101;
  localparam logic [127:0] V1_OUT = 128'h8e4da1bc_01010101_01010101_01010101;
  localparam logic [127:0] V2_IN  = 128'hf20a225c_c6c6c6c6_d4d4d4d5_2d26314c;
  localparam logic [127:0] V2_OUT = 128'h9fdc589d_c6c6c6c6_d5d5d7d6_4d7ebdf8;
  localparam logic [127:0] V3     = 128'h00010203_04050607_08090a0b_0c0d0e0f;

  always #5 clk = ~clk;

  mix_columns_seq #(.COLS_PER_CYCLE(1)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .in_ready(in_ready_w[0]), .state_in(state_in),
    .last_round(last_round), .abort(abort),
    .out_valid(out_valid_w[0]), .out_ready(out_ready),
    .state_out(state_out_w[0]));

  mix_columns_seq #(.COLS_PER_CYCLE(2)) u2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .in_ready(in_ready_w[1]), .state_in(state_in),
    .last_round(last_round), .abort(abort),
    .out_valid(out_valid_w[1]), .out_ready(out_ready),
    .state_out(state_out_w[1]));

  mix_columns_seq #(.COLS_PER_CYCLE(4)) u4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .in_ready(in_ready_w[2]), .state_in(state_in),
    .last_round(last_round), .abort(abort),
    .out_valid(out_valid_w[2]), .out_ready(out_ready),
    .state_out(state_out_w[2]));

  // Offer one block, record first out_valid edge and data per DUT.
  task automatic run_block(input logic [127:0] s, input logic lr);
    for (int i = 0; i < 3; i++) begin
      lat[i] = 0;
      res[i] = '0;
    end
    in_valid = 1'b1;
    state_in = s;
    last_round = lr;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    last_round = 1'b0;
    for (int e = 1; e <= 6; e++) begin
      @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) begin
        if (lat[i] == 0 && out_valid_w[i]) begin
          lat[i] = e;
          res[i] = state_out_w[i];
        end
      end
    end
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (in_ready_w[i] !== 1'b1) begin
        miscompares++;
        $display("FAIL reset_in_ready dut%0d got %b want 1", i, in_ready_w[i]);
      end
      vectors++;
      if (out_valid_w[i] !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_out_valid dut%0d got %b want 0", i, out_valid_w[i]);
      end
      vectors++;
      if (state_out_w[i] !== 128'h0) begin
        miscompares++;
        $display("FAIL reset_state_out dut%0d got %h want 0", i, state_out_w[i]);
      end
    end
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_vector(input string nm, input logic [127:0] din,
                             input logic lr, input logic [127:0] dexp);
    out_ready = 1'b1;
    run_block(din, lr);
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (lat[i] !== exp_lat[i]) begin
        miscompares++;
        $display("FAIL %s_latency dut%0d got %0d want %0d", nm, i, lat[i], exp_lat[i]);
      end
      vectors++;
      if (res[i] !== dexp) begin
        miscompares++;
        $display("FAIL %s_data dut%0d got %h want %h", nm, i, res[i], dexp);
      end
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    in_valid = 1'b1;
    state_in = V2_IN;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) begin
        vectors++;
        if (out_valid_w[i] !== 1'b1 || in_ready_w[i] !== 1'b0 ||
            state_out_w[i] !== V2_OUT) begin
          miscompares++;
          $display("FAIL hold dut%0d cyc%0d got v=%b r=%b d=%h want v=1 r=0 d=%h",
                   i, c, out_valid_w[i], in_ready_w[i], state_out_w[i], V2_OUT);
        end
      end
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (out_valid_w[i] !== 1'b0 || in_ready_w[i] !== 1'b1 ||
          state_out_w[i] !== V2_OUT) begin
        miscompares++;
        $display("FAIL release dut%0d got v=%b r=%b d=%h want v=0 r=1 d=%h",
                 i, out_valid_w[i], in_ready_w[i], state_out_w[i], V2_OUT);
      end
    end
  endtask

  task automatic test_abort();
    logic seen [3];
    for (int i = 0; i < 3; i++) seen[i] = 1'b0;
    out_ready = 1'b0;
    in_valid = 1'b1;
    state_in = V2_IN;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) if (out_valid_w[i]) seen[i] = 1'b1;
    abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (out_valid_w[i] !== 1'b0 || in_ready_w[i] !== 1'b1) begin
        miscompares++;
        $display("FAIL abort_idle dut%0d got v=%b r=%b want v=0 r=1",
                 i, out_valid_w[i], in_ready_w[i]);
      end
    end
    out_ready = 1'b1;
    repeat (5) begin
      @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) if (out_valid_w[i]) seen[i] = 1'b1;
    end
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (seen[i] !== 1'b0) begin
        miscompares++;
        $display("FAIL abort_no_output dut%0d got out_valid=1 want 0", i);
      end
    end
    test_vector("after_abort", V1_IN, 1'b0, V1_OUT);
  endtask

  task automatic test_reset_mid();
    logic seen [3];
    for (int i = 0; i < 3; i++) seen[i] = 1'b0;
    out_ready = 1'b0;
    in_valid = 1'b1;
    state_in = V3;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (out_valid_w[i] !== 1'b0 || in_ready_w[i] !== 1'b1 ||
          state_out_w[i] !== 128'h0) begin
        miscompares++;
        $display("FAIL midreset dut%0d got v=%b r=%b d=%h want v=0 r=1 d=0",
                 i, out_valid_w[i], in_ready_w[i], state_out_w[i]);
      end
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (6) begin
      @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) if (out_valid_w[i]) seen[i] = 1'b1;
    end
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (seen[i] !== 1'b0 || state_out_w[i] !== 128'h0) begin
        miscompares++;
        $display("FAIL midreset_stale dut%0d got v_seen=%b d=%h want 0 and 0",
                 i, seen[i], state_out_w[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_vector("col0", V1_IN, 1'b0, V1_OUT);
    test_vector("fips", V2_IN, 1'b0, V2_OUT);
    test_vector("last_round", V3, 1'b1, V3);
    test_backpressure();
    test_abort();
    test_reset_mid();
    test_vector("post_reset", V2_IN, 1'b0, V2_OUT);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
